// File: rtl/sub32_pkg.sv
// Shared widths and pipeline-register types for the sub32_pipe subtractor.
// SUB32_PIPE_OVF_EN adds a signed-overflow flag to the result record.
package sub32_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SPLIT_DEF = 16;

  typedef struct packed {
    logic [WIDTH_DEF-SPLIT_DEF-1:0] hi_a;
    logic [WIDTH_DEF-SPLIT_DEF-1:0] hi_b;
    logic [SPLIT_DEF-1:0]           lo_diff;
    logic                           borrow1;
  } s1_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] diff;
    logic                 bout;
`ifdef SUB32_PIPE_OVF_EN
    logic                 ovf;
`endif
  } res_t;

endpackage

// File: rtl/sub32_pipe_if.sv
// Valid/ready operand and result bus of sub32_pipe.
// SUB32_PIPE_OVF_EN adds the ovf result signal.
interface sub32_pipe_if
  import sub32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB32_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef SUB32_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef SUB32_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/sub32_pipe_sub_slice.sv
// Combinational N-bit subtract with borrow in and borrow out.
module sub_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic [N-1:0] o_diff,
  output logic         o_bout
);

  logic [N:0] w_full;

  // One extra bit: it goes high exactly when a < b + bin.
  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{N{1'b0}}, i_bin};
  assign o_diff = w_full[N-1:0];
  assign o_bout = w_full[N];

endmodule

// File: rtl/sub32_pipe.sv
// Two-stage valid/ready pipelined subtractor: diff = a - b - bin, bout = borrow.
// Defining SUB32_PIPE_OVF_EN adds a registered two's-complement overflow flag.
module sub32_pipe
  import sub32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SPLIT = SPLIT_DEF
) (
  input logic         clk,
  input logic         rst_n,
  sub32_pipe_if.slave bus
);

  // Pipeline records are typed from the package, so the widths must agree.
  if (WIDTH != WIDTH_DEF || SPLIT != SPLIT_DEF) begin : g_cfg_check
    $error("sub32_pipe: WIDTH/SPLIT must equal the sub32_pkg defaults");
  end

  s1_t  r_s1;
  logic r_s1_valid;
  res_t r_res;
  logic r_s2_valid;

  logic                   w_s2_take;
  logic                   w_s1_take;
  logic                   w_in_fire;
  logic [SPLIT-1:0]       w_lo_diff;
  logic                   w_lo_bout;
  logic [WIDTH-SPLIT-1:0] w_hi_diff;
  logic                   w_hi_bout;
  res_t                   w_res;

  assign w_s2_take = !r_s2_valid || bus.out_ready;
  assign w_s1_take = !r_s1_valid || w_s2_take;
  assign w_in_fire = bus.in_valid && w_s1_take;

  sub_slice #(.N(SPLIT)) u_lo (
    .i_a    (bus.a[SPLIT-1:0]),
    .i_b    (bus.b[SPLIT-1:0]),
    .i_bin  (bus.bin),
    .o_diff (w_lo_diff),
    .o_bout (w_lo_bout)
  );

  sub_slice #(.N(WIDTH-SPLIT)) u_hi (
    .i_a    (r_s1.hi_a),
    .i_b    (r_s1.hi_b),
    .i_bin  (r_s1.borrow1),
    .o_diff (w_hi_diff),
    .o_bout (w_hi_bout)
  );

  always_comb begin
    // NOTE: default the whole record first so no field can infer a latch.
    w_res      = '0;
    w_res.diff = {w_hi_diff, r_s1.lo_diff};
    w_res.bout = w_hi_bout;
`ifdef SUB32_PIPE_OVF_EN
    w_res.ovf  = (r_s1.hi_a[WIDTH-SPLIT-1] != r_s1.hi_b[WIDTH-SPLIT-1]) &&
                 (w_hi_diff[WIDTH-SPLIT-1] != r_s1.hi_a[WIDTH-SPLIT-1]);
`endif
  end

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      // NOTE: data registers are reset too because the result bus must read 0 after reset.
      r_s1       <= '0;
      r_res      <= '0;
    end else begin
      if (w_s1_take) r_s1_valid <= bus.in_valid;
      if (w_in_fire) begin
        r_s1 <= '{hi_a:    bus.a[WIDTH-1:SPLIT],
                  hi_b:    bus.b[WIDTH-1:SPLIT],
                  lo_diff: w_lo_diff,
                  borrow1: w_lo_bout};
      end
      if (w_s2_take) r_s2_valid <= r_s1_valid;
      if (w_s2_take && r_s1_valid) r_res <= w_res;
    end
  end

  assign bus.in_ready  = w_s1_take;
  assign bus.out_valid = r_s2_valid;
  assign bus.diff      = r_res.diff;
  assign bus.bout      = r_res.bout;
`ifdef SUB32_PIPE_OVF_EN
  assign bus.ovf       = r_res.ovf;
`endif

endmodule

// File: tb/tb_sub32_pipe.sv
// Self-checking bench for sub32_pipe: queue-based arithmetic model plus directed literals.
// Build with SUB32_PIPE_OVF_EN defined to also check the ovf flag.
module tb_sub32_pipe;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub32_pipe_if #(.WIDTH(W)) bus ();

  sub32_pipe #(.WIDTH(W), .SPLIT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   n_in  = 0;
  int   n_out = 0;
  exp_t exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_diff  = '0;
  logic         prev_bout  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic: wrapped difference, full-precision borrow, sign-rule overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    e.diff = a - b - W'(bin);
    e.bout = ({1'b0, a} < ({1'b0, b} + (W+1)'(bin)));
    e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
    return e;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_diff",  64'(bus.diff), 64'(prev_diff));
        check("stall_bout",  64'(bus.bout), 64'(prev_bout));
      end
      check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2 || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(bus.out_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_diff", 64'(bus.diff), 64'(e.diff));
          check("out_bout", 64'(bus.bout), 64'(e.bout));
`ifdef SUB32_PIPE_OVF_EN
          check("out_ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.bin));
        n_in++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_diff  = bus.diff;
      prev_bout  = bus.bout;
    end
  end

  // Present one operand set (starting just after a rising edge) until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] x_diff, input logic x_bout,
                         input logic x_ovf);
    bit got = 1'b0;
    send(a, b, bin);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        check({name, "_diff"}, 64'(bus.diff), 64'(x_diff));
        check({name, "_bout"}, 64'(bus.bout), 64'(x_bout));
`ifdef SUB32_PIPE_OVF_EN
        check({name, "_ovf"}, 64'(bus.ovf), 64'(x_ovf));
`else
        if (x_ovf === 1'bx) $display("unused expectation");
`endif
      end
    end
    if (!got) check({name, "_timeout"}, 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  ov_bits;
    logic [W-1:0] bp_a[3];
    logic [W-1:0] bp_b[3];
    int           k;
    int           base;
    int           sent;
    logic         acc;
    logic         last_rdy;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_diff",      64'(bus.diff),      64'd0);
    check("rst_bout",      64'(bus.bout),      64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef SUB32_PIPE_OVF_EN
    check("rst_ovf",       64'(bus.ovf),       64'd0);
`endif
    @(posedge clk);
    #1;

    // Two-edge latency and a single-cycle out_valid pulse.
    send(32'd5, 32'd3, 1'b0);
    @(negedge clk);
    check("lat_stage1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid",  64'(bus.out_valid), 64'd1);
    check("lat_diff",   64'(bus.diff),      64'd2);
    check("lat_bout",   64'(bus.bout),      64'd0);
    @(negedge clk);
    check("lat_pulse",  64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    run_vec("under",     32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_vec("sovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_vec("split",     32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
    run_vec("bin_only",  32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_vec("max_minus", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Back-to-back stream of 8: out_valid high in exactly the 8 cycles starting two edges in.
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        bus.in_valid = 1'b1;
        bus.a   = 32'h1357_9BDF * (i + 1);
        bus.b   = 32'h0246_8ACE * (i * 3 + 1);
        bus.bin = i[0];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      ov_bits[i] = bus.out_valid;
      if (i < 8) check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    check("stream_valid_run", 64'(ov_bits), 64'h03FC);

    // Back-pressure: 3 transactions, out_ready low for 4 cycles.
    bp_a = '{32'h0000_0010, 32'h0001_0000, 32'h8000_0000};
    bp_b = '{32'h0000_0001, 32'h0000_0002, 32'h7FFF_FFFF};
    base = n_out;
    k = 0;
    last_rdy = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = bp_a[0];
    bus.b = bp_b[0];
    bus.bin = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      last_rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 3) begin bus.a = bp_a[k]; bus.b = bp_b[k]; end
        else bus.in_valid = 1'b0;
      end
    end
    check("bp_accepted",     64'(k), 64'd2);
    check("bp_in_ready_low", 64'(last_rdy), 64'd0);
    check("bp_no_output",    64'(n_out - base), 64'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 3; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 3) begin bus.a = bp_a[k]; bus.b = bp_b[k]; end
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    drain();
    check("bp_out_count", 64'(n_out - base), 64'd3);

    // Reset with two transactions in flight.
    base = n_out;
    bus.in_valid = 1'b1;
    bus.a = 32'h1234_5678;
    bus.b = 32'h0000_1111;
    bus.bin = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0BAD_F00D;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_diff",      64'(bus.diff),      64'd0);
    check("mid_rst_bout",      64'(bus.bout),      64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    check("mid_rst_out_count", 64'(n_out - base), 64'd0);
    @(posedge clk);
    #1;

    // Random regression with random gaps and back-pressure.
    base = n_out;
    sent = 0;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (!bus.in_valid || acc) begin
        bus.in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.bin = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("rand_sent",      64'(sent), 64'd1000);
    check("rand_out_count", 64'(n_out - base), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
